sync_ram_arbiter: RTL and testbench
===================================

# sync_ram_arbiter

Two-port round-robin arbiter and sequencer for one single-ported, synchronous-read RAM (1-cycle read latency, read-first on write). It sits between two requesters and the RAM, and grants at most one access per cycle. It routes each read result back to the requester that issued it. It can optionally zero-fill the whole RAM after reset before accepting any traffic.

## Interface
Parameters:
- DWIDTH, 8, data width
- AWIDTH, 8, address width
- DEPTH, 256, number of RAM words (≤ 2^AWIDTH)
- CLEAR_ON_RESET, 1, when 1, zero-fill addresses 0..DEPTH-1 after reset

Ports:
- clk  in  1  sole clock, posedge
- rst  in  1  reset is synchronous and active-high
- init_done  out  1  high once arbitration is enabled
- p0_valid  in  1  port 0 request valid
- p0_ready  out  1  port 0 request accepted this cycle
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  AWIDTH  port 0 address
- p0_wdata  in  DWIDTH  port 0 write data
- p0_resp_valid  out  1  port 0 response pulse
- p0_resp_rdata  out  DWIDTH  port 0 response data
- p1_valid, p1_ready, p1_we, p1_addr, p1_wdata, p1_resp_valid, p1_resp_rdata: same as port 0, for port 1
- mem_addr  out  AWIDTH  RAM address
- mem_d  out  DWIDTH  RAM write data
- mem_we  out  1  RAM write enable
- mem_q  in  DWIDTH  RAM registered read data, valid 1 cycle after address

## Operation
- FSM states:
  - RESET: while rst is high.
  - CLEAR: entered after reset when CLEAR_ON_RESET=1.
  - RUN: entered after CLEAR completes, or directly after reset when CLEAR_ON_RESET=0.
- CLEAR:
  - An AWIDTH-bit counter starts at 0.
  - Each cycle it drives mem_addr=count, mem_d=0, mem_we=1, then increments.
  - After the cycle with count=DEPTH-1, the FSM moves to RUN.
  - Both readys are 0. No resp_valid is generated.
- RUN:
  - A request is accepted on valid&&ready.
  - Ready is combinational: `pX_ready = grantX`. At most one grant per cycle, and only for a port with valid=1.
  - If only one port is valid, it is granted.
  - If both are valid, the port not granted most recently is granted.
  - Priority pointer `last` updates to the granted port on every grant. After reset, last=1, so port 0 wins the first tie.
- The granted request drives mem_addr, mem_d and mem_we combinationally.
  - With no grant: mem_we=0, mem_addr=0, mem_d=0.
- Every accepted request (read or write) produces exactly one response.
  - The response is pX_resp_valid=1 for one cycle, on the following cycle, on the granting port only.
  - pX_resp_rdata = mem_q. For a read this is the stored data. For a write it is the previous contents (read-first).
  - Response data is meaningful only while resp_valid is high. It is not held afterwards.
- There is no response backpressure. Requesters must accept the response pulse.
- A request that is not granted must keep valid and its fields stable. The arbiter does not store it.

## Timing
- Reset values, in the cycle after rst is sampled high:
  - init_done=0, p0_ready=p1_ready=0, p0_resp_valid=p1_resp_valid=0, mem_we=0, last=1, clear counter=0.
- rst high at any time, including mid-CLEAR or with a response pending:
  - Aborts the operation.
  - The pending response is dropped (resp_valid=0 next cycle).
  - CLEAR restarts from address 0 after release.
- CLEAR_ON_RESET=1:
  - The first clear write happens in cycle 1 after rst falls.
  - The last write (DEPTH-1) happens in cycle DEPTH.
  - init_done=1 and requests become grantable from cycle DEPTH+1.
- CLEAR_ON_RESET=0: init_done=1 and granting begins in cycle 1 after rst falls.
- Latency: grant in cycle N gives resp_valid in cycle N+1 with mem_q data.
- Throughput: one access per cycle total, back-to-back grants allowed.
- Fairness: with both ports continuously valid, grants strictly alternate.
- Same-address write in cycle N followed by a read in cycle N+1 returns the new data in cycle N+2.
- Simultaneous events:
  - A response for the grant in cycle N and a new grant in cycle N+1 occur together. They may target the same port or different ports.
  - resp_valid is never asserted on both ports in one cycle.

## Test plan
- CLEAR_ON_RESET=1, DEPTH=16, RAM preloaded with 0xFF:
  - Expected: init_done rises at cycle 17 after reset release, readys are 0 before then, and reads of addresses 0..15 all return 0x00.
- Port 0 writes 0x5A at 3 in cycle N, then reads 3 in cycle N+1:
  - Expected: resp_valid in N+1 with rdata 0x00 (old contents), then resp_valid in N+2 with rdata 0x5A.
- Both ports hold valid continuously for 6 reads, port 0 at addr 1 and port 1 at addr 2, with mem[1]=0x11 and mem[2]=0x22:
  - Expected grant sequence: p0,p1,p0,p1,p0,p1.
  - Each resp_valid lands on the correct port with 0x11 or 0x22, and never on both ports at once.
- Only port 1 valid for 4 cycles:
  - Expected: granted every cycle, port 0 never granted, 4 responses.
- rst asserted at clear count 5, held 1 cycle, then released:
  - Expected: clear restarts at address 0, and init_done follows DEPTH cycles later.
- rst asserted the cycle after a port 0 read grant:
  - Expected: p0_resp_valid stays 0, and all outputs take their reset values.

Source files
------------

// File: rtl/sync_ram_arbiter.sv
// Round-robin arbiter and sequencer for one single-ported RAM with 1-cycle read latency.
// An optional zero-fill pass runs after reset before any requester is granted.
module sync_ram_arbiter #(
    parameter int DWIDTH         = 8,
    parameter int AWIDTH         = 8,
    parameter int DEPTH          = 256,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,

    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [AWIDTH-1:0] p0_addr,
    input  logic [DWIDTH-1:0] p0_wdata,
    output logic              p0_resp_valid,
    output logic [DWIDTH-1:0] p0_resp_rdata,

    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [AWIDTH-1:0] p1_addr,
    input  logic [DWIDTH-1:0] p1_wdata,
    output logic              p1_resp_valid,
    output logic [DWIDTH-1:0] p1_resp_rdata,

    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_d,
    output logic              mem_we,
    input  logic [DWIDTH-1:0] mem_q
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [AWIDTH-1:0] CLR_LAST = AWIDTH'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [AWIDTH-1:0] clr_cnt;
    logic              last;
    logic              grant0;
    logic              grant1;
    logic              resp_vld0_p1;
    logic              resp_vld1_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RESET;
            clr_cnt      <= '0;
            last         <= 1'b1;
            resp_vld0_p1 <= 1'b0;
            resp_vld1_p1 <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (grant0) begin
                last <= 1'b0;
            end else if (grant1) begin
                last <= 1'b1;
            end
            // stage p1: RAM read data arrives together with the response pulse
            resp_vld0_p1 <= grant0;
            resp_vld1_p1 <= grant1;
        end
    end

    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        mem_addr   = '0;
        mem_d      = '0;
        mem_we     = 1'b0;
        case (state)
            ST_RESET: begin
                state_next = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            end
            ST_CLEAR: begin
                mem_addr = clr_cnt;
                mem_we   = 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // last==1 means port 1 was served most recently, so port 0 wins a tie
                grant0 = p0_valid && (!p1_valid || last);
                grant1 = p1_valid && (!p0_valid || !last);
                if (grant0) begin
                    mem_addr = p0_addr;
                    mem_d    = p0_wdata;
                    mem_we   = p0_we;
                end else if (grant1) begin
                    mem_addr = p1_addr;
                    mem_d    = p1_wdata;
                    mem_we   = p1_we;
                end
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase
    end

    assign init_done     = (state == ST_RUN);
    assign p0_ready      = grant0;
    assign p1_ready      = grant1;
    assign p0_resp_valid = resp_vld0_p1;
    assign p1_resp_valid = resp_vld1_p1;
    assign p0_resp_rdata = mem_q;
    assign p1_resp_rdata = mem_q;

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Scoreboard bench for sync_ram_arbiter: a behavioural RAM, a reference model of
// arbitration/clear timing, and directed plus random request traffic.
module tb_sync_ram_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done;
    logic          p0_valid = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p0_ready, p0_resp_valid;
    logic [DW-1:0] p0_resp_rdata;
    logic          p1_valid = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p1_ready, p1_resp_valid;
    logic [DW-1:0] p1_resp_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_d;
    logic          mem_we;
    logic [DW-1:0] mem_q;

    sync_ram_arbiter #(
        .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
        .mem_addr(mem_addr), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural RAM, preloaded with 0xFF so the zero-fill is observable
    logic [DW-1:0] ram [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'hFF;
        forever begin
            @(posedge clk);
            mem_q <= ram[mem_addr];
            if (mem_we) ram[mem_addr] <= mem_d;
        end
    end

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          expq[$];
    logic [DW-1:0] model [0:DEPTH-1];
    int            rel = 0;
    bit            started = 0;
    bit            last_m = 1'b1;
    int            gcnt0 = 0;
    int            gcnt1 = 0;

    // Monitor: tracks cycles since reset release, predicts grants and bus, checks responses
    initial begin
        exp_t          e;
        bit            run, e0, e1;
        logic [AW+DW:0] em;
        forever begin
            @(posedge clk);
            if (rst) begin
                rel = 0;
                started = 1;
                expq.delete();
                last_m = 1'b1;
            end else if (started) begin
                rel++;
            end
            @(negedge clk);
            if (started) begin
                run = (rel >= DEPTH + 1);
                chk("init_done", 32'(init_done), 32'(run));
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("resp_valid", {p0_resp_valid, p1_resp_valid}, e.port ? 2'b01 : 2'b10);
                    chk("resp_rdata", e.port ? p1_resp_rdata : p0_resp_rdata, e.data);
                end else begin
                    chk("resp_idle", {p0_resp_valid, p1_resp_valid}, 2'b00);
                end
                e0 = 0;
                e1 = 0;
                if (run) begin
                    e0 = p0_valid && (!p1_valid || last_m);
                    e1 = p1_valid && !e0;
                end
                chk("ready", {p0_ready, p1_ready}, {e0, e1});
                em = '0;
                if (rel >= 1 && rel <= DEPTH) begin
                    em = {1'b1, AW'(rel - 1), 8'h00};
                    model[rel-1] = '0;
                end else if (e0) begin
                    em = {p0_we, p0_addr, p0_wdata};
                end else if (e1) begin
                    em = {p1_we, p1_addr, p1_wdata};
                end
                chk("mem_bus", {mem_we, mem_addr, mem_d}, em);
                if (e0) begin
                    expq.push_back('{1'b0, model[p0_addr]});
                    if (p0_we) model[p0_addr] = p0_wdata;
                    last_m = 1'b0;
                end else if (e1) begin
                    expq.push_back('{1'b1, model[p1_addr]});
                    if (p1_we) model[p1_addr] = p1_wdata;
                    last_m = 1'b1;
                end
                if (p0_valid && p0_ready) gcnt0++;
                if (p1_valid && p1_ready) gcnt1++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic wait_init(input string name);
        int k = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (init_done) break;
        end
        chk(name, k, DEPTH + 1);
    endtask

    task automatic issue(input int port, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got = 0;
        if (port == 0) begin
            p0_valid = 1; p0_we = we; p0_addr = a; p0_wdata = d;
        end else begin
            p1_valid = 1; p1_we = we; p1_addr = a; p1_wdata = d;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((port == 0) ? p0_ready : p1_ready) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("issue_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (port == 0) p0_valid = 0; else p1_valid = 0;
    endtask

    initial begin
        int n, g0s, g1s;
        bit a0, a1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_init_done", 32'(init_done), 32'd0);
        chk("reset_readys", {p0_ready, p1_ready, mem_we}, 3'b000);
        rst = 0;
        wait_init("init_latency");

        for (int i = 0; i < DEPTH; i++) issue(0, 0, AW'(i), 8'h00);

        issue(0, 1, 4'd3, 8'h5A);
        issue(0, 0, 4'd3, 8'h00);
        repeat (2) @(posedge clk);
        #1;

        // Port 1 writes last so the pointer favours port 0 on the first tie
        issue(0, 1, 4'd1, 8'h11);
        issue(1, 1, 4'd2, 8'h22);
        g0s = gcnt0;
        g1s = gcnt1;
        p0_valid = 1; p0_we = 0; p0_addr = 4'd1;
        p1_valid = 1; p1_we = 0; p1_addr = 4'd2;
        n = 0;
        for (int i = 0; i < 20 && n < 6; i++) begin
            @(negedge clk);
            if (p0_ready || p1_ready) n++;
            @(posedge clk);
            #1;
        end
        p0_valid = 0;
        p1_valid = 0;
        @(posedge clk);
        #1;
        chk("fair_p0_grants", gcnt0 - g0s, 3);
        chk("fair_p1_grants", gcnt1 - g1s, 3);

        g0s = gcnt0;
        g1s = gcnt1;
        p1_valid = 1; p1_we = 0; p1_addr = 4'd2;
        repeat (4) @(posedge clk);
        #1;
        p1_valid = 0;
        @(posedge clk);
        #1;
        chk("p1only_p1_grants", gcnt1 - g1s, 4);
        chk("p1only_p0_grants", gcnt0 - g0s, 0);

        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            a0 = p0_valid && p0_ready;
            a1 = p1_valid && p1_ready;
            @(posedge clk);
            #1;
            if (!p0_valid || a0) begin
                p0_valid = 1'($urandom_range(0, 1)); p0_we = 1'($urandom_range(0, 1));
                p0_addr = AW'($urandom_range(0, DEPTH - 1)); p0_wdata = DW'($urandom);
            end
            if (!p1_valid || a1) begin
                p1_valid = 1'($urandom_range(0, 1)); p1_we = 1'($urandom_range(0, 1));
                p1_addr = AW'($urandom_range(0, DEPTH - 1)); p1_wdata = DW'($urandom);
            end
        end
        p0_valid = 0;
        p1_valid = 0;

        // Reset while the clear pass is writing address 5
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("midclear_addr", 32'(mem_addr), 32'd5);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        wait_init("reclear_latency");
        for (int i = 0; i < 6; i++) issue(i % 2, 0, AW'($urandom_range(0, DEPTH - 1)), 8'h00);

        // Reset arriving with a port 0 read grant in flight
        p0_valid = 1; p0_we = 0; p0_addr = 4'd7;
        rst = 1;
        @(posedge clk);
        #1;
        chk("rst_resp_dropped", 32'(p0_resp_valid), 32'd0);
        chk("rst_outputs", {init_done, p0_ready, p1_ready, mem_we}, 4'b0000);
        p0_valid = 0;
        rst = 0;
        wait_init("post_rst_latency");
        issue(1, 0, 4'd7, 8'h00);
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
